// File: rtl/action_arb_pkg.sv
// Shared definitions for the action arbiter: command codes, FSM encoding,
// pending-bit layout and the fixed-priority winner selection.
package action_arb_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_AWAKE = 3'd1,
        CMD_SLEEP = 3'd2,
        CMD_FEED  = 3'd3,
        CMD_PLAY  = 3'd4,
        CMD_GIRO  = 3'd5,
        CMD_TICK  = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COOL  = 2'd3
    } arb_state_e;

    localparam int PEND_W   = 5;
    localparam int PB_AWAKE = 0;
    localparam int PB_SLEEP = 1;
    localparam int PB_FEED  = 2;
    localparam int PB_PLAY  = 3;
    localparam int PB_GIRO  = 4;

    // AWAKE > SLEEP > FEED > PLAY > GIRO > TICK
    function automatic cmd_e pick_winner(input logic [PEND_W-1:0] pend, input logic tick);
        if (pend[PB_AWAKE])     return CMD_AWAKE;
        else if (pend[PB_SLEEP]) return CMD_SLEEP;
        else if (pend[PB_FEED])  return CMD_FEED;
        else if (pend[PB_PLAY])  return CMD_PLAY;
        else if (pend[PB_GIRO])  return CMD_GIRO;
        else if (tick)           return CMD_TICK;
        return CMD_NONE;
    endfunction

    function automatic logic [PEND_W-1:0] cmd_mask(input cmd_e c);
        case (c)
            CMD_AWAKE: return 5'b00001;
            CMD_SLEEP: return 5'b00010;
            CMD_FEED:  return 5'b00100;
            CMD_PLAY:  return 5'b01000;
            CMD_GIRO:  return 5'b10000;
            default:   return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/action_arbiter_edge.sv
// Registered rising-edge detector; the first clock after reset only loads
// the history so inputs already high at release do not count as edges.
module action_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic hist_q;
    logic primed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= d_i;
            primed_q <= 1'b1;
        end
    end

    assign rise_o = primed_q & d_i & ~hist_q;

endmodule

// File: rtl/action_arbiter.sv
// Fixed-priority command arbiter feeding the pet FSM (IDLE/ISSUE/WAIT/COOLDOWN).
// Define ACTION_ARB_TEST_EN to enable the botonTest/pulseTest TICK burst.
module action_arbiter
    import action_arb_pkg::*;
#(
    parameter int COOLDOWN = 4,
    parameter int TIMEOUT  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       botonSleep,
    input  logic       botonAwake,
    input  logic       botonFeed,
    input  logic       botonPlay,
    input  logic       giro,
    input  logic       botonTest,
    input  logic [3:0] pulseTest,
    input  logic       core_busy,
    input  logic       core_death,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [4:0] pending,
    output logic [1:0] arb_state,
    output logic       drop_pulse,
    output logic       timeout_err
);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CD_W-1:0]   CD_LAST   = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    logic [PEND_W-1:0] req;
    logic [PEND_W-1:0] rise;
    logic              test_rise;
    arb_state_e        state_q, state_d;
    cmd_e              win_q, win_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CD_W-1:0]   cd_cnt_q, cd_cnt_d;
    logic              timeout_q, timeout_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              drop_q, drop_d;
    logic              tick_nz;
    logic              issuing;

    assign req = {giro, botonPlay, botonFeed, botonSleep, botonAwake};

    for (genvar i = 0; i < PEND_W; i++) begin : g_edge
        action_edge u_edge (.clk(clk), .rst(rst), .d_i(req[i]), .rise_o(rise[i]));
    end
    action_edge u_edge_test (.clk(clk), .rst(rst), .d_i(botonTest), .rise_o(test_rise));

    assign issuing = (state_q == ST_ISSUE) && !core_death;

`ifdef ACTION_ARB_TEST_EN
    logic [3:0] tick_q, tick_d;

    // A new botonTest edge overrides the decrement of a TICK grant in the same cycle
    always_comb begin
        tick_d = tick_q;
        if (core_death) begin
            tick_d = '0;
        end else begin
            if (issuing && win_q == CMD_TICK && tick_q != '0) tick_d = tick_q - 4'd1;
            if (test_rise && pulseTest != '0) tick_d = pulseTest;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tick_q <= '0;
        else      tick_q <= tick_d;
    end

    assign tick_nz = (tick_q != '0);
`else
    logic unused_test;
    assign unused_test = &{1'b0, test_rise, pulseTest};
    assign tick_nz     = 1'b0;
`endif

    // The winner is cleared before edges are applied, so its own edge re-arms it without a drop
    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        if (core_death) begin
            pend_d = '0;
        end else begin
            if (issuing) pend_d = pend_q & ~cmd_mask(win_q);
            for (int i = 0; i < PEND_W; i++) begin
                if (rise[i]) begin
                    if (pend_d[i]) drop_d = 1'b1;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            win_q      <= CMD_NONE;
            wait_cnt_q <= '0;
            cd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            wait_cnt_q <= wait_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        wait_cnt_d = wait_cnt_q;
        cd_cnt_d   = cd_cnt_q;
        timeout_d  = timeout_q;
        if (core_death) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            cd_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pend_q || tick_nz) begin
                        state_d = ST_ISSUE;
                        win_d   = pick_winner(pend_q, tick_nz);
                    end
                end
                ST_ISSUE: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
                ST_WAIT: begin
                    if (!core_busy) begin
                        state_d  = ST_COOL;
                        cd_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_COOL;
                        cd_cnt_d  = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_COOL: begin
                    if (cd_cnt_q == CD_LAST) state_d = ST_IDLE;
                    else                     cd_cnt_d = cd_cnt_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_valid = issuing;
        cmd_code  = issuing ? win_q : CMD_NONE;
        arb_state = state_q;
    end

    assign pending     = pend_q;
    assign drop_pulse  = drop_q;
    assign timeout_err = timeout_q;

endmodule

// File: doc/action_arbiter.md
ACTION_ARBITER -- requirements
Module: action_arbiter

Interface
REQ-001 Parameter COOLDOWN, default 4: idle cycles enforced after each completed command.
REQ-002 Parameter TIMEOUT, default 20: maximum cycles WAIT tolerates core_busy before abort.
REQ-003 clk  in  1  system clock, all logic rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 botonSleep / botonAwake / botonFeed / botonPlay / giro  in  1 each  user requests, level inputs already synchronous.
REQ-006 botonTest  in  1  test-burst request; pulseTest  in  4  burst length.
REQ-007 core_busy  in  1  pet FSM executing a command; core_death  in  1  pet FSM in DEATH.
REQ-008 cmd_valid  out  1  one-cycle command strobe to pet FSM; cmd_code  out  3  command code, valid with cmd_valid.
REQ-009 pending  out  5  pending bits {giro,play,feed,sleep,awake}; arb_state  out  2  current FSM state.
REQ-010 drop_pulse  out  1  one-cycle flag, request lost; timeout_err  out  1  sticky WAIT-abort flag.

Function
REQ-011 Each request input rising edge SHALL set its pending bit the following cycle.
REQ-012 Rising edge while its bit already set SHALL leave the bit set and assert drop_pulse for one cycle.
REQ-013 Codes: 0 NONE, 1 AWAKE, 2 SLEEP, 3 FEED, 4 PLAY, 5 GIRO, 6 TICK; cmd_code SHALL be 0 whenever cmd_valid=0.
REQ-014 Fixed priority AWAKE > SLEEP > FEED > PLAY > GIRO > TICK.
REQ-015 States IDLE(0), ISSUE(1), WAIT(2), COOLDOWN(3).
REQ-016 IDLE -> ISSUE when any pending bit set or tick burst nonzero; winner latched on transition.
REQ-017 ISSUE lasts exactly one cycle: cmd_valid=1, cmd_code=winner, winner pending bit cleared; then WAIT.
REQ-018 Edge of the winner's input during the ISSUE clear cycle SHALL win: bit remains set, no drop_pulse.
REQ-019 WAIT samples core_busy from the first cycle after ISSUE; core_busy=0 -> COOLDOWN.
REQ-020 WAIT counter reaching TIMEOUT-1 with core_busy=1 -> set timeout_err, go COOLDOWN.
REQ-021 COOLDOWN holds COOLDOWN cycles then IDLE; COOLDOWN=0 returns to IDLE next cycle.
REQ-022 Requests arriving in WAIT/COOLDOWN SHALL only accumulate as pending; never issued early.
REQ-023 core_death=1 in any state: clear all pending and tick burst, force IDLE next cycle, suppress cmd_valid; requests ignored while asserted.
REQ-024 Counters sized $clog2(param+1); no wrap-around permitted.

Reset
REQ-025 rst low SHALL immediately clear: state IDLE, pending 0, cmd_valid 0, cmd_code 0, drop_pulse 0, timeout_err 0, counters 0, edge-history registers 0.
REQ-026 Reset mid-WAIT SHALL abandon the command silently; no strobe on release.
REQ-027 First cycle after release SHALL not detect edges from inputs already high (history loads from inputs at first clock).

Configuration
REQ-028 Macro ACTION_ARB_TEST_EN defined: botonTest rising edge loads pulseTest into tick burst counter (0 = no-op); each TICK grant decrements it; edge during nonzero burst overwrites count.
REQ-029 Macro undefined: botonTest and pulseTest ignored, TICK never issued, ports retained.

Structure
REQ-030 Package action_arb_pkg SHALL hold command codes, state encoding, and pending bit indices.
REQ-031 Sub-module action_edge: single-bit registered rising-edge detector, instantiated six times.

Verification
REQ-032 Feed pulse, core_busy high 3 cycles -> cmd_valid=1, cmd_code=3 once; arb_state 1,2,2,2,3x4,0.
REQ-033 Sleep+Play+Awake same cycle -> codes 1,2,4 in order, each separated by WAIT+COOLDOWN.
REQ-034 Feed pulsed twice during WAIT -> pending[2]=1, drop_pulse=1 on second edge, one extra FEED issued.
REQ-035 core_busy stuck high -> exit WAIT after 20 cycles, timeout_err=1 until rst.
REQ-036 core_death asserted with 3 pending -> pending=0 next cycle, no cmd_valid while high.
REQ-037 ACTION_ARB_TEST_EN, pulseTest=5, botonTest pulse -> five cmd_code=6 strobes; macro off -> none.
